rv_status_led: RTL and testbench

RV_STATUS_LED -- requirements
Module: rv_status_led

---
 rtl/rv_status_led_pkg.sv | 23 ++
 rtl/rv_status_led_stretch.sv | 42 ++++
 rtl/rv_status_led.sv | 116 +++++++++++
 tb/tb_rv_status_led.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rv_status_led_pkg.sv
// Shared types and timing derivations for the rv_status_led status-LED block.
package rv_status_led_pkg;

    typedef enum logic [1:0] {
        LEVEL   = 2'd0,
        STICKY  = 2'd1,
        STRETCH = 2'd2,
        BLINK   = 2'd3
    } mode_t;

    // Half blink period in clock cycles; 0 flags an unusable configuration.
    function automatic int unsigned calc_half_cyc(input int unsigned clock_freq,
                                                  input int unsigned blink_hz);
        if (blink_hz == 0) return 0;
        return clock_freq / (2 * blink_hz);
    endfunction

    function automatic int unsigned calc_stretch_cyc(input int unsigned clock_freq,
                                                     input int unsigned stretch_ms);
        return (clock_freq / 1000) * stretch_ms;
    endfunction

endpackage

// File: rtl/rv_status_led_stretch.sv
// Per-channel rising-edge detector and retriggerable pulse-stretch timer.
module rv_status_led_stretch #(
    parameter int unsigned STRETCH_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stretch_nxt
);

    localparam int TW = $clog2(STRETCH_CYC + 1);
    localparam logic [TW-1:0] LOAD = TW'(STRETCH_CYC);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] timer_p1;
    logic          din_p1;
    logic          armed_p1;
    logic          edge_det;

    // armed_p1 masks the first post-reset cycle so a level already high is not an edge.
    assign edge_det = armed_p1 & din & ~din_p1;

    // Value the registered LED should take next: high for exactly STRETCH_CYC cycles.
    assign stretch_nxt = edge_det | (timer_p1 > ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_p1 <= '0;
            din_p1   <= 1'b0;
            armed_p1 <= 1'b0;
        end else begin
            armed_p1 <= 1'b1;
            din_p1   <= din;
            if (edge_det) begin
                timer_p1 <= LOAD;
            end else if (timer_p1 != '0) begin
                timer_p1 <= timer_p1 - ONE;
            end
        end
    end

endmodule

// File: rtl/rv_status_led.sv
// Multi-channel status LED driver: level, sticky, stretch and blink modes per channel.
// Optional heartbeat output enabled by defining RV_STATUS_LED_HEARTBEAT_EN.
module rv_status_led
    import rv_status_led_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned BLINK_HZ   = 2,
    parameter int unsigned STRETCH_MS = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_in,
    input  logic [2*NUM_CH-1:0]   ch_mode,
    input  logic                  clr_sticky,
    output logic [NUM_CH-1:0]     led
`ifdef RV_STATUS_LED_HEARTBEAT_EN
    ,
    output logic                  heartbeat
`endif
);

    localparam int unsigned HALF_CYC    = calc_half_cyc(CLOCK_FREQ, BLINK_HZ);
    localparam int unsigned STRETCH_CYC = calc_stretch_cyc(CLOCK_FREQ, STRETCH_MS);
    localparam int          PW          = $clog2(HALF_CYC + 1);

    if (HALF_CYC == 0) begin : g_bad_half
        $error("rv_status_led: HALF_CYC evaluates to 0");
    end
    if (STRETCH_CYC == 0) begin : g_bad_stretch
        $error("rv_status_led: STRETCH_CYC evaluates to 0");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("rv_status_led: NUM_CH must be within 1..16");
    end

    logic [PW-1:0]     cnt_p1;
    logic              blink_phase;
    logic              wrap;
    logic [NUM_CH-1:0] sticky_p1;
    logic [NUM_CH-1:0] sticky_nxt;
    logic [NUM_CH-1:0] stretch_nxt;
    logic [NUM_CH-1:0] led_p0;
    logic [NUM_CH-1:0] led_p1;

    assign wrap = (cnt_p1 == PW'(HALF_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_p1      <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            cnt_p1      <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            cnt_p1      <= cnt_p1 + PW'(1);
        end
    end

    // A new event in the same cycle as a clear keeps the latch set.
    assign sticky_nxt = ch_in | (sticky_p1 & {NUM_CH{~clr_sticky}});

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rv_status_led_stretch #(
            .STRETCH_CYC(STRETCH_CYC)
        ) u_stretch (
            .clk        (clk),
            .rst_n      (rst_n),
            .din        (ch_in[i]),
            .stretch_nxt(stretch_nxt[i])
        );
    end

    // Every channel's state runs regardless of mode; the mode only selects the source.
    always_comb begin
        led_p0 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_t'(ch_mode[2*i +: 2]))
                LEVEL:   led_p0[i] = ch_in[i];
                STICKY:  led_p0[i] = sticky_nxt[i];
                STRETCH: led_p0[i] = stretch_nxt[i];
                BLINK:   led_p0[i] = ch_in[i] & blink_phase;
                default: led_p0[i] = 1'b0;
            endcase
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_p1 <= '0;
            led_p1    <= '0;
        end else begin
            sticky_p1 <= sticky_nxt;
            led_p1    <= led_p0;
        end
    end

    assign led = led_p1;

`ifdef RV_STATUS_LED_HEARTBEAT_EN
    logic hb_p1;

    // Toggles on every second prescaler wrap, i.e. half the blink rate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_p1 <= 1'b0;
        end else if (wrap && blink_phase) begin
            hb_p1 <= ~hb_p1;
        end
    end

    assign heartbeat = hb_p1;
`endif

endmodule

// File: tb/tb_rv_status_led.sv
// Self-checking bench for rv_status_led: directed vector table, blink sequence, randomized model run.
module tb_rv_status_led;

    localparam int HALF = 5;
    localparam int SCYC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ch_in;
    logic [3:0] ch_mode;
    logic       clr_sticky;
    logic [1:0] led;
`ifdef RV_STATUS_LED_HEARTBEAT_EN
    logic       heartbeat;
`endif

    always #5 clk = ~clk;

    rv_status_led #(
        .CLOCK_FREQ(1000),
        .NUM_CH    (2),
        .BLINK_HZ  (100),
        .STRETCH_MS(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_in     (ch_in),
        .ch_mode   (ch_mode),
        .clr_sticky(clr_sticky),
        .led       (led)
`ifdef RV_STATUS_LED_HEARTBEAT_EN
        ,
        .heartbeat (heartbeat)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: counts cycles since reset release and timestamps of edges.
    int         m_n;
    bit         m_first;
    logic [1:0] m_prev;
    logic [1:0] m_sticky;
    int         m_last [2];
    logic [1:0] m_led;
    logic       m_hb;

    function automatic void model_step();
        int phase;
        if (!rst_n) begin
            m_n = 0; m_first = 1'b1; m_prev = 2'b00; m_sticky = 2'b00;
            m_last[0] = -100; m_last[1] = -100; m_led = 2'b00; m_hb = 1'b0;
            return;
        end
        phase = (m_n / HALF) % 2;
        for (int i = 0; i < 2; i++) begin
            if (!m_first && ch_in[i] && !m_prev[i]) m_last[i] = m_n;
            m_sticky[i] = ch_in[i] | (m_sticky[i] & ~clr_sticky);
            case (ch_mode[2*i +: 2])
                2'd0: m_led[i] = ch_in[i];
                2'd1: m_led[i] = m_sticky[i];
                2'd2: m_led[i] = ((m_n - m_last[i]) < SCYC);
                default: m_led[i] = ch_in[i] & (phase == 1);
            endcase
        end
        m_prev  = ch_in;
        m_first = 1'b0;
        m_n++;
        m_hb = (((m_n / (2 * HALF)) % 2) == 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [1:0] in;
        logic [3:0] mode;
        logic       clr;
        logic [1:0] exp;
    } vec_t;

    vec_t tbl [26];

    initial begin
        // ch1 STICKY / ch0 STRETCH, then LEVEL, then both STRETCH and reset abort
        tbl[0]  = '{1'b0, 2'b00, 4'b0110, 1'b0, 2'b00};
        tbl[1]  = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b00};
        tbl[2]  = '{1'b1, 2'b01, 4'b0110, 1'b0, 2'b01};
        tbl[3]  = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b01};
        tbl[4]  = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b01};
        tbl[5]  = '{1'b1, 2'b01, 4'b0110, 1'b0, 2'b01};
        tbl[6]  = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b01};
        tbl[7]  = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b01};
        tbl[8]  = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b01};
        tbl[9]  = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b00};
        tbl[10] = '{1'b1, 2'b10, 4'b0110, 1'b0, 2'b10};
        tbl[11] = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b10};
        tbl[12] = '{1'b1, 2'b00, 4'b0110, 1'b1, 2'b00};
        tbl[13] = '{1'b1, 2'b10, 4'b0110, 1'b1, 2'b10};
        tbl[14] = '{1'b1, 2'b00, 4'b0110, 1'b0, 2'b10};
        tbl[15] = '{1'b1, 2'b11, 4'b0000, 1'b0, 2'b11};
        tbl[16] = '{1'b1, 2'b00, 4'b0000, 1'b0, 2'b00};
        tbl[17] = '{1'b1, 2'b11, 4'b1010, 1'b0, 2'b11};
        tbl[18] = '{1'b1, 2'b11, 4'b1010, 1'b0, 2'b11};
        tbl[19] = '{1'b1, 2'b11, 4'b1010, 1'b0, 2'b11};
        tbl[20] = '{1'b1, 2'b11, 4'b1010, 1'b0, 2'b11};
        tbl[21] = '{1'b1, 2'b11, 4'b1010, 1'b0, 2'b00};
        tbl[22] = '{1'b0, 2'b11, 4'b1010, 1'b0, 2'b00};
        tbl[23] = '{1'b0, 2'b11, 4'b1010, 1'b0, 2'b00};
        tbl[24] = '{1'b1, 2'b11, 4'b1010, 1'b0, 2'b00};
        tbl[25] = '{1'b1, 2'b11, 4'b1010, 1'b0, 2'b00};

        rst_n = 1'b0; ch_in = 2'b00; ch_mode = 4'b0000; clr_sticky = 1'b0;
        tick();
        tick();
        check("reset_led", {30'd0, led}, 32'd0);
`ifdef RV_STATUS_LED_HEARTBEAT_EN
        check("reset_hb", {31'd0, heartbeat}, 32'd0);
`endif

        for (int v = 0; v < 26; v++) begin
            rst_n = tbl[v].rst_n; ch_in = tbl[v].in; ch_mode = tbl[v].mode; clr_sticky = tbl[v].clr;
            tick();
            check($sformatf("vec%0d_led", v), {30'd0, led}, {30'd0, tbl[v].exp});
        end

        // Blink on both channels from a fresh reset: 5 cycles low, 5 high, one cycle late.
        rst_n = 1'b0; ch_in = 2'b00; clr_sticky = 1'b0;
        tick();
        rst_n = 1'b1; ch_in = 2'b11; ch_mode = 4'b1111;
        for (int k = 1; k <= 30; k++) begin
            tick();
            check($sformatf("blink%0d_led", k), {30'd0, led},
                  (((k - 1) / HALF) % 2 == 1) ? 32'd3 : 32'd0);
`ifdef RV_STATUS_LED_HEARTBEAT_EN
            check($sformatf("blink%0d_hb", k), {31'd0, heartbeat},
                  ((k / (2 * HALF)) % 2 == 1) ? 32'd1 : 32'd0);
`endif
        end

        // Randomized run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            ch_in[0]   = ($urandom_range(0, 9) < 3);
            ch_in[1]   = ($urandom_range(0, 9) < 3);
            clr_sticky = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) ch_mode = 4'($urandom_range(0, 15));
            tick();
            check("rand_led", {30'd0, led}, {30'd0, m_led});
`ifdef RV_STATUS_LED_HEARTBEAT_EN
            check("rand_hb", {31'd0, heartbeat}, {31'd0, m_hb});
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
